tenthirty_round_ctrl: RTL and testbench

//   Round sequencer for the ten-and-a-half game. It requests cards from the card source
//   (pip/number handshake) and runs player then dealer turns from debounced button pulses.
//   It keeps both hand scores in half-points, decides each round's winner and counts rounds
//   to game end. It drives the result LEDs and exports scores and counts to the seg7 driver.

---
 rtl/tenthirty_pkg.sv | 19 +
 rtl/tenthirty_hand.sv | 27 ++
 rtl/tenthirty_round_ctrl.sv | 107 ++++++++++
 tb/tb_tenthirty_round_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tenthirty_pkg.sv
// Shared types and helpers for the ten-and-a-half round sequencer.
// Scores are kept in half-points so that face cards (0.5) stay integral.
package tenthirty_pkg;

  typedef enum logic [3:0] {
    P_REQ, P_WAIT, P_TURN, D_REQ, D_WAIT, D_EVAL, COMPARE, RESULT, DONE
  } state_t;

  localparam int SCORE_W = 6;
  localparam int CNT_W   = 3;
  localparam logic [SCORE_W-1:0] BUST_HALF = 6'd21;

  // Ranks 1..10 count double, face cards count one half-point.
  function automatic logic [SCORE_W-1:0] card_half(input logic [3:0] rank);
    if (rank >= 4'd11) return 6'd1;
    return {1'b0, rank, 1'b0};
  endfunction

endpackage

// File: rtl/tenthirty_hand.sv
// One hand: half-point score accumulator plus card counter.
module tenthirty_hand
  import tenthirty_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add,
  input  logic [SCORE_W-1:0] half,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
      cnt   <= '0;
    end else if (clr) begin
      score <= '0;
      cnt   <= '0;
    end else if (add) begin
      score <= score + half;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tenthirty_round_ctrl.sv
// Ten-and-a-half round sequencer: card requests, player/dealer turns,
// round decision, round counting and result LEDs.
module tenthirty_round_ctrl
  import tenthirty_pkg::*;
#(
  parameter int ROUNDS       = 4,
  parameter int MAX_CARDS    = 5,
  parameter int DEALER_STAND = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         draw_p,
  input  logic         stand_p,
  input  logic         number_valid,
  input  logic [3:0]   number,
  output logic         pip,
  output logic [5:0]   player_score,
  output logic [5:0]   dealer_score,
  output logic [2:0]   player_cnt,
  output logic [2:0]   dealer_cnt,
  output logic [3:0]   last_card,
  output logic [2:0]   round_no,
  output logic         dealer_turn,
  output logic [2:0]   led
);

  localparam logic [CNT_W-1:0]   MAX_C     = CNT_W'(MAX_CARDS);
  localparam logic [SCORE_W-1:0] STAND_H   = SCORE_W'(DEALER_STAND);
  localparam logic [2:0]         LAST_RND  = 3'(ROUNDS);

  state_t state, state_nx;

  logic rank_ok, p_add, d_add, p_bust, d_bust, p_wins, last_round, clr_hands;
  logic [SCORE_W-1:0] card_val;

  assign rank_ok    = (number >= 4'd1) && (number <= 4'd13);
  assign card_val   = card_half(number);
  assign p_add      = (state == P_WAIT) && number_valid && rank_ok;
  assign d_add      = (state == D_WAIT) && number_valid && rank_ok;
  assign p_bust     = player_score > BUST_HALF;
  assign d_bust     = dealer_score > BUST_HALF;
  assign p_wins     = d_bust || (player_score > dealer_score);
  assign last_round = (round_no == LAST_RND);
  assign clr_hands  = (state == RESULT) && draw_p && !last_round;

  tenthirty_hand u_player (
    .clk(clk), .rst(rst), .clr(clr_hands), .add(p_add), .half(card_val),
    .score(player_score), .cnt(player_cnt)
  );

  tenthirty_hand u_dealer (
    .clk(clk), .rst(rst), .clr(clr_hands), .add(d_add), .half(card_val),
    .score(dealer_score), .cnt(dealer_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= P_REQ;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    // Reset parks the FSM in P_REQ, so the request is masked while rst is held.
    pip         = ((state == P_REQ) || (state == D_REQ)) && !rst;
    dealer_turn = (state == D_REQ) || (state == D_WAIT) || (state == D_EVAL) ||
                  (state == COMPARE) || (state == RESULT);
    unique case (state)
      P_REQ:   state_nx = P_WAIT;
      P_WAIT:  if (number_valid) state_nx = rank_ok ? P_TURN : P_REQ;
      P_TURN: begin
        if (p_bust)                   state_nx = RESULT;
        else if (player_cnt == MAX_C) state_nx = D_REQ;
        else if (stand_p)             state_nx = D_REQ;
        else if (draw_p)              state_nx = P_REQ;
      end
      D_REQ:   state_nx = D_WAIT;
      D_WAIT:  if (number_valid) state_nx = rank_ok ? D_EVAL : D_REQ;
      D_EVAL: begin
        if (d_bust || dealer_score >= STAND_H || dealer_cnt == MAX_C) state_nx = COMPARE;
        else                                                          state_nx = D_REQ;
      end
      COMPARE: state_nx = RESULT;
      RESULT:  if (draw_p) state_nx = last_round ? DONE : P_REQ;
      DONE:    state_nx = DONE;
      default: state_nx = P_REQ;
    endcase
  end

  // Round counter, displayed rank and result LEDs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_no  <= 3'd1;
      led       <= '0;
      last_card <= '0;
    end else begin
      if (p_add || d_add) last_card <= number;
      if (state == P_TURN && p_bust) led[1:0] <= 2'b01;
      if (state == COMPARE) led[1:0] <= p_wins ? 2'b10 : 2'b01;
      if (clr_hands) begin
        led[1:0] <= 2'b00;
        round_no <= round_no + 3'd1;
      end
      if (state == RESULT && draw_p && last_round) led[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tenthirty_round_ctrl.sv
// Directed bench for tenthirty_round_ctrl: a queued card source answers each
// pip, and four scripted rounds plus reset cases are checked against hand values.
module tb_tenthirty_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       draw_p = 1'b0;
  logic       stand_p = 1'b0;
  logic       number_valid = 1'b0;
  logic [3:0] number = 4'd0;
  logic       pip;
  logic [5:0] player_score, dealer_score;
  logic [2:0] player_cnt, dealer_cnt;
  logic [3:0] last_card;
  logic [2:0] round_no;
  logic       dealer_turn;
  logic [2:0] led;

  int checks = 0;
  int errors = 0;
  int pip_cnt = 0;
  int pip_base = 0;
  logic prev_pip = 1'b0;
  logic pend = 1'b0;
  logic [3:0] pend_rank = 4'd0;
  logic [3:0] deck[$];

  tenthirty_round_ctrl dut (
    .clk(clk), .rst(rst), .draw_p(draw_p), .stand_p(stand_p),
    .number_valid(number_valid), .number(number), .pip(pip),
    .player_score(player_score), .dealer_score(dealer_score),
    .player_cnt(player_cnt), .dealer_cnt(dealer_cnt), .last_card(last_card),
    .round_no(round_no), .dealer_turn(dealer_turn), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Card source: answers a pip one cycle later with the next queued rank.
  always @(negedge clk) begin
    number_valid = 1'b0;
    if (pend) begin
      number_valid = 1'b1;
      number       = pend_rank;
      pend         = 1'b0;
    end
    if (pip) begin
      pip_cnt++;
      chk("pip_back_to_back", prev_pip, 0);
      if (deck.size() > 0) begin
        pend      = 1'b1;
        pend_rank = deck.pop_front();
      end
    end
    prev_pip = pip;
  end

  task automatic pulse(input logic d, input logic s);
    draw_p  = d;
    stand_p = s;
    @(negedge clk);
    draw_p  = 1'b0;
    stand_p = 1'b0;
  endtask

  task automatic wait_pcnt(input int k);
    int n = 0;
    while (player_cnt != 3'(k) && n < 40) begin @(negedge clk); n++; end
    chk("wait_player_cnt", player_cnt, k);
  endtask

  task automatic wait_dcnt(input int k);
    int n = 0;
    while (dealer_cnt != 3'(k) && n < 40) begin @(negedge clk); n++; end
    chk("wait_dealer_cnt", dealer_cnt, k);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pip"}, pip, 0);
    chk({tag, "_pscore"}, player_score, 0);
    chk({tag, "_dscore"}, dealer_score, 0);
    chk({tag, "_pcnt"}, player_cnt, 0);
    chk({tag, "_dcnt"}, dealer_cnt, 0);
    chk({tag, "_last"}, last_card, 0);
    chk({tag, "_round"}, round_no, 1);
    chk({tag, "_dturn"}, dealer_turn, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");

    // Round 1: player 10,11 = 21, stand; dealer 3,5 = 16 -> player wins.
    deck = '{4'd10, 4'd11, 4'd3, 4'd5};
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    wait_pcnt(1);
    chk("r1_p1_score", player_score, 20);
    pulse(1'b1, 1'b0);
    wait_pcnt(2);
    chk("r1_p_score", player_score, 21);
    chk("r1_last", last_card, 11);
    pulse(1'b0, 1'b1);
    wait_dcnt(2);
    repeat (2) @(negedge clk);
    chk("r1_d_score", dealer_score, 16);
    chk("r1_dturn", dealer_turn, 1);
    chk("r1_led", led, 3'b010);
    pip_base = pip_cnt;

    // Round 2: player 9,5 = 28 busts; dealer never draws.
    deck = '{4'd9, 4'd5};
    pulse(1'b1, 1'b0);
    chk("r2_round", round_no, 2);
    chk("r2_clr_led", led, 0);
    chk("r2_clr_score", player_score, 0);
    wait_pcnt(1);
    pulse(1'b1, 1'b0);
    wait_pcnt(2);
    repeat (4) @(negedge clk);
    chk("r2_p_score", player_score, 28);
    chk("r2_dcnt", dealer_cnt, 0);
    chk("r2_led", led, 3'b001);
    chk("r2_pips", pip_cnt - pip_base, 2);

    // Round 3: player 5,2 = 14; dealer 7 = 14 stops, tie -> dealer.
    deck = '{4'd5, 4'd2, 4'd7};
    pulse(1'b1, 1'b0);
    chk("r3_round", round_no, 3);
    wait_pcnt(1);
    pulse(1'b1, 1'b0);
    wait_pcnt(2);
    chk("r3_p_score", player_score, 14);
    pulse(1'b0, 1'b1);
    wait_dcnt(1);
    repeat (2) @(negedge clk);
    chk("r3_d_score", dealer_score, 14);
    chk("r3_led", led, 3'b001);

    // Round 4: five face cards force stand at 5; dealer 6,10 = 32 busts.
    deck = '{4'd11, 4'd12, 4'd13, 4'd11, 4'd12, 4'd6, 4'd10};
    pulse(1'b1, 1'b0);
    chk("r4_round", round_no, 4);
    for (int k = 1; k <= 4; k++) begin
      wait_pcnt(k);
      pulse(1'b1, 1'b0);
    end
    wait_pcnt(5);
    chk("r4_p_score", player_score, 5);
    wait_dcnt(2);
    repeat (2) @(negedge clk);
    chk("r4_d_score", dealer_score, 32);
    chk("r4_led", led, 3'b010);

    // Final acknowledge -> DONE; further pulses ignored.
    pulse(1'b1, 1'b0);
    chk("done_led", led, 3'b110);
    chk("done_dturn", dealer_turn, 0);
    pip_base = pip_cnt;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_led_hold", led, 3'b110);
    chk("done_round_hold", round_no, 4);
    chk("done_no_pip", pip_cnt - pip_base, 0);
    chk("done_hand_kept", player_score, 5);

    // Asynchronous reset out of DONE.
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_done");

    // Bad ranks 0 and 15 are discarded and re-requested.
    deck = '{4'd0, 4'd15, 4'd3};
    pip_base = pip_cnt;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    wait_pcnt(1);
    chk("bad_pips", pip_cnt - pip_base, 3);
    chk("bad_score", player_score, 6);
    chk("bad_last", last_card, 3);

    // Reset while waiting for a card (no card queued).
    pulse(1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_wait");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
